// File: rtl/am_trainer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : am_trainer_pkg
//  Description : Shared dimensions, counter width and FSM state type for the
//                associative-memory trainer.
//  Revision    : 1.0 - initial release
// ============================================================================
package am_trainer_pkg;

   // Hypervector length, number of classes and label width.
   localparam int HV_DIMENSION    = 16;
   localparam int CLASSES         = 2;
   localparam int LABEL_WIDTH     = 2;

   // Width of each signed saturating training counter.
   localparam int TRAIN_CNT_WIDTH = 8;

   // Trainer control states.
   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_EMIT  = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

endpackage : am_trainer_pkg
`default_nettype wire

// File: rtl/am_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : am_bit_counter
//  Description : One signed saturating up/down counter with synchronous clear.
//                Reports whether the current and the next count are strictly
//                positive.
//  Revision    : 1.0 - initial release
// ============================================================================
module am_bit_counter #(
   parameter int WIDTH = 8
) (
   input  logic Clk_CI,
   input  logic Rst_RI,
   input  logic Clear_SI,
   input  logic Enable_SI,
   input  logic Up_SI,
   output logic Pos_SO,
   output logic PosNext_SO
);

   localparam logic [WIDTH-1:0] c_cnt_max = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_cnt_min = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   // Next count: clear wins, otherwise step toward the input bit and stick at the rails.
   always_comb begin
      cnt_d = cnt_q;
      if (Clear_SI) begin
         cnt_d = '0;
      end else if (Enable_SI) begin
         if (Up_SI) begin
            if (cnt_q != c_cnt_max) begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            if (cnt_q != c_cnt_min) begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
   end

   // Count register.
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Strictly positive means sign bit clear and value non-zero; a tie reads as 0.
   assign Pos_SO     = ~cnt_q[WIDTH-1] & (|cnt_q);
   assign PosNext_SO = ~cnt_d[WIDTH-1] & (|cnt_d);

endmodule : am_bit_counter
`default_nettype wire

// File: rtl/am_trainer.sv
`default_nettype none
// ============================================================================
//  Module      : am_trainer
//  Description : Associative-memory trainer. Bundles labelled training
//                hypervectors into per-class saturating counters and, on a
//                finalize request, streams out one thresholded prototype per
//                class, then clears all counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module am_trainer
   import am_trainer_pkg::*;
(
   input  logic                    Clk_CI,
   input  logic                    Reset_RI,
   input  logic                    ValidIn_SI,
   output logic                    ReadyOut_SO,
   input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
   input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
   input  logic                    TrainDone_SI,
   output logic                    ValidOut_SO,
   input  logic                    ReadyIn_SI,
   output logic [0:HV_DIMENSION-1] PrototypeOut_DO,
   output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
   output logic                    DropOut_SO
);

   state_e                  state_d, state_q;
   logic [LABEL_WIDTH-1:0]  cls_d, cls_q;
   logic [0:HV_DIMENSION-1] proto_d, proto_q;
   logic                    drop_d, drop_q;

   logic                    accept_w;
   logic                    in_range_w;
   logic                    clear_w;
   logic [LABEL_WIDTH-1:0]  cls_nxt_w;
   logic [CLASSES-1:0]      cls_en_w;

   // Per-class thresholded views of the counter array (current and next value).
   logic [0:HV_DIMENSION-1] pos_w      [CLASSES];
   logic [0:HV_DIMENSION-1] pos_next_w [CLASSES];

   assign ReadyOut_SO = (state_q == ST_ACCUM);
   assign ValidOut_SO = (state_q == ST_EMIT);
   assign clear_w     = (state_q == ST_CLEAR);
   assign accept_w    = ValidIn_SI & ReadyOut_SO;
   assign in_range_w  = (32'(LabelIn_DI) < CLASSES);
   assign cls_nxt_w   = cls_q + LABEL_WIDTH'(1);

   // Counter array: one saturating counter per bit per class.
   for (genvar c = 0; c < CLASSES; c++) begin : g_class
      assign cls_en_w[c] = accept_w & (32'(LabelIn_DI) == c);

      for (genvar i = 0; i < HV_DIMENSION; i++) begin : g_bit
         am_bit_counter #(
            .WIDTH (TRAIN_CNT_WIDTH)
         ) u_bit_counter (
            .Clk_CI     (Clk_CI),
            .Rst_RI     (Reset_RI),
            .Clear_SI   (clear_w),
            .Enable_SI  (cls_en_w[c]),
            .Up_SI      (HypervectorIn_DI[i]),
            .Pos_SO     (pos_w[c][i]),
            .PosNext_SO (pos_next_w[c][i])
         );
      end
   end

   // Next-state logic; the class-0 prototype is taken from the next counter
   // value so that a sample accepted alongside the finalize request is included.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      proto_d = proto_q;
      drop_d  = accept_w & ~in_range_w;

      case (state_q)
         ST_ACCUM: begin
            if (TrainDone_SI) begin
               state_d = ST_EMIT;
               cls_d   = '0;
               proto_d = pos_next_w[0];
            end
         end

         ST_EMIT: begin
            if (ReadyIn_SI) begin
               if (32'(cls_q) == CLASSES - 1) begin
                  state_d = ST_CLEAR;
               end else begin
                  cls_d = cls_nxt_w;
                  for (int c = 0; c < CLASSES; c++) begin
                     if (32'(cls_nxt_w) == c) begin
                        proto_d = pos_w[c];
                     end
                  end
               end
            end
         end

         ST_CLEAR: begin
            state_d = ST_ACCUM;
         end

         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         state_q <= ST_ACCUM;
         cls_q   <= '0;
         proto_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         proto_q <= proto_d;
         drop_q  <= drop_d;
      end
   end

   assign PrototypeOut_DO = proto_q;
   assign LabelOut_DO     = cls_q;
   assign DropOut_SO      = drop_q;

endmodule : am_trainer
`default_nettype wire

// File: tb/tb_am_trainer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am_trainer
//  Description : Self-checking bench for am_trainer with a behavioural model
//                of class counters and a queue of expected prototypes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_am_trainer;
   import am_trainer_pkg::*;

   localparam int CMAX = (2 ** (TRAIN_CNT_WIDTH - 1)) - 1;
   localparam int CMIN = -(2 ** (TRAIN_CNT_WIDTH - 1));

   logic                    clk;
   logic                    rst;
   logic                    valid_in;
   logic                    ready_out;
   logic [0:HV_DIMENSION-1] hv_in;
   logic [LABEL_WIDTH-1:0]  label_in;
   logic                    train_done;
   logic                    valid_out;
   logic                    ready_in;
   logic [0:HV_DIMENSION-1] proto_out;
   logic [LABEL_WIDTH-1:0]  label_out;
   logic                    drop_out;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   am_trainer u_dut (
      .Clk_CI           (clk),
      .Reset_RI         (rst),
      .ValidIn_SI       (valid_in),
      .ReadyOut_SO      (ready_out),
      .HypervectorIn_DI (hv_in),
      .LabelIn_DI       (label_in),
      .TrainDone_SI     (train_done),
      .ValidOut_SO      (valid_out),
      .ReadyIn_SI       (ready_in),
      .PrototypeOut_DO  (proto_out),
      .LabelOut_DO      (label_out),
      .DropOut_SO       (drop_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int                      cnt [CLASSES][HV_DIMENSION];
   int                      q_lbl [$];
   logic [0:HV_DIMENSION-1] q_pro [$];
   bit                      m_clearing;
   bit                      m_drop;

   function automatic logic [0:HV_DIMENSION-1] model_proto(input int c);
      logic [0:HV_DIMENSION-1] p;
      for (int i = 0; i < HV_DIMENSION; i++) p[i] = (cnt[c][i] > 0);
      return p;
   endfunction

   task automatic model_zero();
      for (int c = 0; c < CLASSES; c++)
         for (int i = 0; i < HV_DIMENSION; i++) cnt[c][i] = 0;
   endtask

   task automatic model_step();
      int l;
      m_drop = 0;
      if (rst) begin
         model_zero();
         q_lbl.delete();
         q_pro.delete();
         m_clearing = 0;
      end else if (m_clearing) begin
         model_zero();
         m_clearing = 0;
      end else if (q_lbl.size() != 0) begin
         if (ready_in) begin
            void'(q_lbl.pop_front());
            void'(q_pro.pop_front());
            if (q_lbl.size() == 0) m_clearing = 1;
         end
      end else begin
         if (valid_in) begin
            l = int'(label_in);
            if (l < CLASSES) begin
               for (int i = 0; i < HV_DIMENSION; i++) begin
                  if (hv_in[i]) cnt[l][i] = (cnt[l][i] + 1 > CMAX) ? CMAX : cnt[l][i] + 1;
                  else          cnt[l][i] = (cnt[l][i] - 1 < CMIN) ? CMIN : cnt[l][i] - 1;
               end
            end else begin
               m_drop = 1;
            end
         end
         if (train_done) begin
            for (int c = 0; c < CLASSES; c++) begin
               q_lbl.push_back(c);
               q_pro.push_back(model_proto(c));
            end
         end
      end
   endtask

   initial begin
      model_zero();
      m_clearing = 0;
      m_drop     = 0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("m_ready", 32'(ready_out), 32'((q_lbl.size() == 0) && !m_clearing));
            chk("m_valid", 32'(valid_out), 32'(q_lbl.size() != 0));
            chk("m_drop",  32'(drop_out),  32'(m_drop));
            if (q_lbl.size() != 0) begin
               chk("m_label", 32'(label_out), 32'(q_lbl[0]));
               chk("m_proto", 32'(proto_out), 32'(q_pro[0]));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [0:HV_DIMENSION-1] hv, input int lbl);
      valid_in = 1'b1;
      hv_in    = hv;
      label_in = LABEL_WIDTH'(lbl);
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic send_n(input logic [0:HV_DIMENSION-1] hv, input int lbl, input int n);
      for (int k = 0; k < n; k++) send(hv, lbl);
   endtask

   task automatic finalize();
      train_done = 1'b1;
      @(negedge clk);
      train_done = 1'b0;
   endtask

   // Drain both prototypes with ReadyIn high and check them against literals.
   task automatic emit_check(input logic [0:HV_DIMENSION-1] e0, input logic [0:HV_DIMENSION-1] e1);
      logic [0:HV_DIMENSION-1] ep [CLASSES];
      int k;
      ep[0] = e0;
      ep[1] = e1;
      ready_in = 1'b1;
      for (int c = 0; c < CLASSES; c++) begin
         k = 0;
         while (!valid_out && k < 8) begin
            @(negedge clk);
            k++;
         end
         chk("emit_valid", 32'(valid_out), 32'd1);
         chk("emit_label", 32'(label_out), 32'(c));
         chk("emit_proto", 32'(proto_out), 32'(ep[c]));
         @(negedge clk);
      end
      chk("clear_ready", 32'(ready_out), 32'd0);
      chk("clear_valid", 32'(valid_out), 32'd0);
      @(negedge clk);
      chk("accum_ready", 32'(ready_out), 32'd1);
   endtask

   initial begin
      rst        = 1'b1;
      valid_in   = 1'b0;
      hv_in      = '0;
      label_in   = '0;
      train_done = 1'b0;
      ready_in   = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_ready", 32'(ready_out), 32'd1);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_proto", 32'(proto_out), 32'd0);
      chk("rst_label", 32'(label_out), 32'd0);
      chk("rst_drop",  32'(drop_out),  32'd0);
      chk_en = 1;

      // No samples: both prototypes zero
      finalize();
      emit_check(16'h0000, 16'h0000);

      // Majority of three class-0 samples
      send(16'h8000, 0);
      send(16'h8000, 0);
      send(16'h4000, 0);
      finalize();
      emit_check(16'h8000, 16'h0000);

      // Tie on class-1 bit 2 reads as 0
      send(16'h2000, 1);
      send(16'h0000, 1);
      send(16'h00FF, 0);
      finalize();
      emit_check(16'h00FF, 16'h0000);

      // Sample accepted together with the finalize request
      valid_in   = 1'b1;
      hv_in      = 16'hF0F0;
      label_in   = 2'd1;
      train_done = 1'b1;
      @(negedge clk);
      valid_in   = 1'b0;
      train_done = 1'b0;
      emit_check(16'h0000, 16'hF0F0);

      // Saturation just short of cancelling
      send_n(16'hFFFF, 0, 200);
      send_n(16'h0000, 0, 126);
      send_n(16'h0000, 1, 200);
      send_n(16'hFFFF, 1, 129);
      finalize();
      emit_check(16'hFFFF, 16'hFFFF);

      // Saturation exactly cancelled: counters land on 0
      send_n(16'hFFFF, 0, 200);
      send_n(16'h0000, 0, 127);
      send_n(16'h0000, 1, 200);
      send_n(16'hFFFF, 1, 128);
      finalize();
      emit_check(16'h0000, 16'h0000);

      // Out-of-range label is dropped; backpressure holds the output
      send(16'h0F0F, 0);
      send(16'hFFFF, 2);
      chk("drop_pulse", 32'(drop_out), 32'd1);
      @(negedge clk);
      chk("drop_end", 32'(drop_out), 32'd0);
      ready_in = 1'b0;
      finalize();
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", 32'(valid_out), 32'd1);
         chk("hold_ready", 32'(ready_out), 32'd0);
         chk("hold_proto", 32'(proto_out), 32'h0F0F);
         chk("hold_label", 32'(label_out), 32'd0);
         @(negedge clk);
      end
      emit_check(16'h0F0F, 16'h0000);

      // Reset in the second EMIT cycle abandons emission and accumulation
      send(16'hFFFF, 0);
      send(16'hFFFF, 1);
      ready_in = 1'b0;
      finalize();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", 32'(valid_out), 32'd0);
      chk("mid_rst_ready", 32'(ready_out), 32'd1);
      ready_in = 1'b1;
      finalize();
      emit_check(16'h0000, 16'h0000);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_am_trainer
`default_nettype wire
